da_bit_serial_mac: RTL
======================

// Module: da_bit_serial_mac
// PURPOSE
//  Distributed-arithmetic (DA) shift-accumulate engine for one DCT output coefficient. Accepts
//  three signed input samples and sends them to the coefficient ROM one bit-plane at a time,
//  LSB first. The ROM is the combinational, 3-bit-address, 16-bit-data partial-sum ROM, for
//  example ROM2_Z2. The engine accumulates the returned partial sums with binary weights and
//  presents the full-precision coefficient on a valid/ready output.
// PARAMETERS
//  DATA_W  16  width of each signed two's-complement input sample (= number of bit-planes)
//  ROM_W   16  width of signed ROM data word (fixed-point partial sums)
//  ACC_W   derived localparam = ROM_W+DATA_W; width of result, no truncation/rounding
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       x1/x2/x3 valid
//  in_ready   out  1       engine can accept a new sample set
//  x1         in   DATA_W  signed sample feeding ROM addr[2]
//  x2         in   DATA_W  signed sample feeding ROM addr[1]
//  x3         in   DATA_W  signed sample feeding ROM addr[0]
//  rom_addr   out  3       ROM address = {x1[j],x2[j],x3[j]} for current bit-plane j
//  rom_cs     out  1       ROM chip select; high only while scanning bit-planes
//  rom_data   in   ROM_W   signed ROM word, combinational response to rom_addr/rom_cs
//  out_valid  out  1       coefficient valid
//  out_ready  in   1       downstream accepts coefficient
//  out_data   out  ACC_W   signed coefficient
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_data=0, rom_cs=0,
//   rom_addr=0, bit counter=0, accumulator=0, sample shift registers=0.
//  FSM, 3 states:
//   IDLE: in_ready=1, rom_cs=0, rom_addr=0.
//    - in_valid=1 at a clock edge: latch x1,x2,x3; clear accumulator; j=0; go to RUN.
//   RUN: in_ready=0, rom_cs=1, rom_addr driven from bit j of the latched samples.
//    - Each cycle samples rom_data in the same cycle. No ROM pipeline stage.
//    - j<DATA_W-1: acc += sext(rom_data)<<j.
//    - j==DATA_W-1 (sign bit-plane): acc -= sext(rom_data)<<(DATA_W-1); load out_data; go to DONE.
//    - RUN lasts exactly DATA_W cycles.
//   DONE: out_valid=1, in_ready=0, rom_cs=0, rom_addr=0.
//    - out_data is held stable while out_ready=0.
//    - out_ready=1 at a clock edge: out_valid drops and the FSM returns to IDLE.
//    - A new set is not accepted in the same cycle as the output handshake.
//  Result: out_data = sum_{j=0}^{DATA_W-2} R(j)*2^j - R(DATA_W-1)*2^(DATA_W-1),
//   where R(j) = signed rom_data at bit-plane j. All arithmetic is ACC_W-bit signed.
//   Because ACC_W = ROM_W+DATA_W, the result never overflows.
//  Timing:
//   - Sample set accepted at edge T.
//   - rom_cs is high for cycles T+1..T+DATA_W.
//   - out_valid rises after edge T+DATA_W, i.e. DATA_W+1 cycles after acceptance.
//   - Throughput is at best one coefficient per DATA_W+2 cycles.
//  in_valid is ignored outside IDLE. Input samples may change once accepted.
//  Reset during RUN or DONE aborts the operation. No partial result is ever emitted.
// TESTING (bench ROM model: rom_data = 100*addr, combinational, 0 when cs=0; DATA_W=16)
//  1. x1=x2=x3=0 -> rom_addr=0 for all 16 RUN cycles; out_data=0; out_valid asserted 17 cycles after accept.
//  2. x3=1, x1=x2=0 -> rom_addr=3'b001 in first RUN cycle, then 0; out_data=100.
//  3. x3=16'hFFFF (-1), x1=x2=0 -> out_data=-100.
//     x1=16'h7FFF, x2=x3=0 -> out_data=400*32767=13106800.
//  4. out_ready held 0 for 5 cycles in DONE -> out_valid=1 and out_data stable.
//     While held: in_ready=0, rom_cs=0, and in_valid pulses are ignored.
//  5. rst asserted at the 7th RUN cycle -> immediately state IDLE, rom_cs=0, out_valid=0, in_ready=1.
//     Next set x2=2 -> out_data=400.
//  6. Back-to-back: in_valid held 1, out_ready held 1 -> sets accepted every 18 cycles.
//     Results match a reference model for 1000 random signed sample sets.

Source files
------------

// File: rtl/da_bit_serial_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | da_bit_serial_mac: LSB-first distributed-arithmetic shift-accumulate     |
// | engine for one DCT coefficient. Revision: 1.0                            |
// +--------------------------------------------------------------------------+
module da_bit_serial_mac #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 16,
  localparam int ACC_W = ROM_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       x1,
  input  logic [DATA_W-1:0]       x2,
  input  logic [DATA_W-1:0]       x3,
  output logic [2:0]              rom_addr,
  output logic                    rom_cs,
  input  logic signed [ROM_W-1:0] rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic [CNT_W-1:0]          j_q, j_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   out_data_q, out_data_d;
  logic signed [ACC_W-1:0]   rom_ext;
  logic signed [ACC_W-1:0]   term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x1_q       <= '0;
      x2_q       <= '0;
      x3_q       <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      x3_q       <= x3_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  // Partial sum weighted by the current bit-plane; the sample registers shift
  // right so bit 0 always holds bit-plane j.
  always_comb begin
    rom_ext = {{DATA_W{rom_data[ROM_W-1]}}, rom_data};
    term    = rom_ext <<< j_q;
  end

  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    x3_d       = x3_q;
    j_d        = j_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x1_d    = x1;
          x2_d    = x2;
          x3_d    = x3;
          acc_d   = '0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x1_d = x1_q >> 1;
        x2_d = x2_q >> 1;
        x3_d = x3_q >> 1;
        if (j_q == CNT_W'(DATA_W - 1)) begin
          // Sign bit-plane carries negative weight in two's complement.
          acc_d      = acc_q - term;
          out_data_d = acc_q - term;
          j_d        = '0;
          state_d    = S_DONE;
        end else begin
          acc_d = acc_q + term;
          j_d   = j_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    rom_cs    = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
    rom_addr  = (state_q == S_RUN) ? {x1_q[0], x2_q[0], x3_q[0]} : 3'b000;
    out_data  = out_data_q;
  end

endmodule
`default_nettype wire
